// File: rtl/reservation_station_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_pkg
// Purpose  : Shared widths, types and operand wakeup helper for the RS slice.
// Revision : 1.0
// ============================================================================
package reservation_station_pkg;

    localparam int C_RS_SIZE   = 16;
    localparam int C_OPENUM_W  = 6;
    localparam int C_DATA_W    = 32;
    localparam int C_ROB_POS_W = 4;
    localparam int C_IMM_W     = 32;
    localparam int C_ADDR_W    = 32;

    typedef logic [C_OPENUM_W-1:0]         openum_t;
    typedef logic [C_DATA_W-1:0]           data_t;
    typedef logic [C_ROB_POS_W-1:0]        rob_pos_t;
    typedef logic [C_IMM_W-1:0]            imm_t;
    typedef logic [C_ADDR_W-1:0]           addr_t;
    typedef logic [$clog2(C_RS_SIZE)-1:0]  rs_pos_t;

    localparam openum_t C_OP_ADD  = 6'd1;
    localparam openum_t C_OP_ADDI = 6'd2;

    typedef struct packed {
        data_t    val;
        rob_pos_t tag;
    } operand_t;

    typedef struct packed {
        openum_t  openum;
        operand_t op1;
        operand_t op2;
        imm_t     imm;
        addr_t    pc;
        rob_pos_t rob_pos;
    } rs_entry_t;

    function automatic logic operand_ready(input rob_pos_t tag);
        return tag == '0;
    endfunction

    // A waiting operand grabs a matching broadcast; the ALU result wins a tie.
    function automatic operand_t wake(input operand_t o,
                                      input logic a_rdy, input rob_pos_t a_tag, input data_t a_val,
                                      input logic l_rdy, input rob_pos_t l_tag, input data_t l_val);
        operand_t r;
        r = o;
        if (o.tag != '0) begin
            if (a_rdy && a_tag == o.tag) begin
                r.val = a_val;
                r.tag = '0;
            end else if (l_rdy && l_tag == o.tag) begin
                r.val = l_val;
                r.tag = '0;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station_if
// Purpose  : Issue, dispatch and result-broadcast bundle for the RS.
// Revision : 1.0
// ============================================================================
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic     rdy;
    logic     rollback;
    logic     rs_enable;
    openum_t  issue_openum;
    data_t    issue_rs1_val;
    rob_pos_t issue_rs1_rob_pos;
    data_t    issue_rs2_val;
    rob_pos_t issue_rs2_rob_pos;
    imm_t     issue_imm;
    addr_t    issue_pc;
    rob_pos_t issue_rob_pos;
    logic     rs_full;
    logic     alu_enable;
    openum_t  alu_openum;
    data_t    alu_rs1_val;
    data_t    alu_rs2_val;
    imm_t     alu_imm;
    addr_t    alu_pc;
    rob_pos_t alu_rob_pos;
    logic     alu_result_ready;
    rob_pos_t alu_result_rob_pos;
    data_t    alu_result_val;
    logic     lsb_load_result_ready;
    rob_pos_t lsb_load_result_rob_pos;
    data_t    lsb_load_result_val;

    modport master (
        output rdy, rollback, rs_enable, issue_openum, issue_rs1_val, issue_rs1_rob_pos,
               issue_rs2_val, issue_rs2_rob_pos, issue_imm, issue_pc, issue_rob_pos,
               alu_result_ready, alu_result_rob_pos, alu_result_val,
               lsb_load_result_ready, lsb_load_result_rob_pos, lsb_load_result_val,
        input  rs_full, alu_enable, alu_openum, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc,
               alu_rob_pos
    );

    modport slave (
        input  rdy, rollback, rs_enable, issue_openum, issue_rs1_val, issue_rs1_rob_pos,
               issue_rs2_val, issue_rs2_rob_pos, issue_imm, issue_pc, issue_rob_pos,
               alu_result_ready, alu_result_rob_pos, alu_result_val,
               lsb_load_result_ready, lsb_load_result_rob_pos, lsb_load_result_val,
        output rs_full, alu_enable, alu_openum, alu_rs1_val, alu_rs2_val, alu_imm, alu_pc,
               alu_rob_pos
    );

endinterface
`default_nettype wire

// File: rtl/reservation_station_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_select
// Purpose  : Lowest-index priority encoder with found flag.
// Revision : 1.0
// ============================================================================
module rs_select #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Purpose  : Tag-wakeup reservation station feeding a single ALU port.
// Revision : 1.0
// ============================================================================
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE = C_RS_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave bus
);

    localparam int C_IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int C_CNT_W = $clog2(RS_SIZE + 1);

    rs_entry_t          r_entry [RS_SIZE];
    logic [RS_SIZE-1:0] r_busy;
    logic               r_alu_enable;
    openum_t            r_alu_openum;
    data_t              r_alu_rs1_val;
    data_t              r_alu_rs2_val;
    imm_t               r_alu_imm;
    addr_t              r_alu_pc;
    rob_pos_t           r_alu_rob_pos;

    logic [RS_SIZE-1:0] w_free;
    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_found;
    logic               w_ready_found;
    logic [C_IDX_W-1:0] w_free_idx;
    logic [C_IDX_W-1:0] w_ready_idx;
    logic [C_CNT_W-1:0] w_count;
    rs_entry_t          w_issue;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_slot
        assign w_free[g]  = ~r_busy[g];
        assign w_ready[g] = r_busy[g] & operand_ready(r_entry[g].op1.tag)
                                      & operand_ready(r_entry[g].op2.tag);
    end

    rs_select #(.N(RS_SIZE), .IDX_W(C_IDX_W)) u_free_sel (
        .i_req   (w_free),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_select #(.N(RS_SIZE), .IDX_W(C_IDX_W)) u_ready_sel (
        .i_req   (w_ready),
        .o_found (w_ready_found),
        .o_idx   (w_ready_idx)
    );

    always_comb begin
        w_count = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_count = w_count + C_CNT_W'(r_busy[i]);
        end
    end

    assign w_issue = '{openum:  bus.issue_openum,
                       op1:     '{val: bus.issue_rs1_val, tag: bus.issue_rs1_rob_pos},
                       op2:     '{val: bus.issue_rs2_val, tag: bus.issue_rs2_rob_pos},
                       imm:     bus.issue_imm,
                       pc:      bus.issue_pc,
                       rob_pos: bus.issue_rob_pos};

    // One slot of slack covers an issue already in flight when full rises.
    assign bus.rs_full = (w_count >= C_CNT_W'(RS_SIZE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_alu_enable  <= 1'b0;
            r_alu_openum  <= '0;
            r_alu_rs1_val <= '0;
            r_alu_rs2_val <= '0;
            r_alu_imm     <= '0;
            r_alu_pc      <= '0;
            r_alu_rob_pos <= '0;
        end else if (!bus.rdy) begin
            r_alu_enable <= 1'b0;
        end else if (bus.rollback) begin
            r_busy       <= '0;
            r_alu_enable <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_entry[i].op1 <= wake(r_entry[i].op1,
                                           bus.alu_result_ready, bus.alu_result_rob_pos, bus.alu_result_val,
                                           bus.lsb_load_result_ready, bus.lsb_load_result_rob_pos,
                                           bus.lsb_load_result_val);
                    r_entry[i].op2 <= wake(r_entry[i].op2,
                                           bus.alu_result_ready, bus.alu_result_rob_pos, bus.alu_result_val,
                                           bus.lsb_load_result_ready, bus.lsb_load_result_rob_pos,
                                           bus.lsb_load_result_val);
                end
            end
            if (bus.rs_enable && w_free_found) begin
                r_entry[w_free_idx] <= w_issue;
                r_busy[w_free_idx]  <= 1'b1;
            end
            r_alu_enable <= w_ready_found;
            if (w_ready_found) begin
                r_busy[w_ready_idx] <= 1'b0;
                r_alu_openum        <= r_entry[w_ready_idx].openum;
                r_alu_rs1_val       <= r_entry[w_ready_idx].op1.val;
                r_alu_rs2_val       <= r_entry[w_ready_idx].op2.val;
                r_alu_imm           <= r_entry[w_ready_idx].imm;
                r_alu_pc            <= r_entry[w_ready_idx].pc;
                r_alu_rob_pos       <= r_entry[w_ready_idx].rob_pos;
            end
        end
    end

    assign bus.alu_enable  = r_alu_enable;
    assign bus.alu_openum  = r_alu_openum;
    assign bus.alu_rs1_val = r_alu_rs1_val;
    assign bus.alu_rs2_val = r_alu_rs2_val;
    assign bus.alu_imm     = r_alu_imm;
    assign bus.alu_pc      = r_alu_pc;
    assign bus.alu_rob_pos = r_alu_rob_pos;

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Purpose  : Directed stimulus with a slot-array model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = 16;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    reservation_station_if bus ();

    reservation_station #(.RS_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an array of slots, filled lowest-free-first, drained lowest-ready-first.
    logic        m_busy [N];
    logic [5:0]  m_op   [N];
    logic [31:0] m_v1   [N];
    logic [31:0] m_v2   [N];
    logic [31:0] m_imm  [N];
    logic [31:0] m_pc   [N];
    logic [3:0]  m_t1   [N];
    logic [3:0]  m_t2   [N];
    logic [3:0]  m_rob  [N];
    logic        e_en;
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic exp_full();
        int cnt;
        cnt = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) cnt++;
        return cnt >= N - 1;
    endfunction

    function automatic logic [31:0] pick_val(input logic [3:0] tag, input logic [31:0] v);
        if (tag == 4'd0) return v;
        if (bus.alu_result_ready && bus.alu_result_rob_pos == tag) return bus.alu_result_val;
        if (bus.lsb_load_result_ready && bus.lsb_load_result_rob_pos == tag) return bus.lsb_load_result_val;
        return v;
    endfunction

    function automatic logic [3:0] pick_tag(input logic [3:0] tag);
        if (tag == 4'd0) return tag;
        if (bus.alu_result_ready && bus.alu_result_rob_pos == tag) return 4'd0;
        if (bus.lsb_load_result_ready && bus.lsb_load_result_rob_pos == tag) return 4'd0;
        return tag;
    endfunction

    always @(posedge clk) begin : model
        int pick;
        int slot;
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            e_en = 1'b0; e_op = '0; e_v1 = '0; e_v2 = '0; e_imm = '0; e_pc = '0; e_rob = '0;
        end else if (!bus.rdy) begin
            e_en = 1'b0;
        end else if (bus.rollback) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            e_en = 1'b0;
        end else begin
            pick = -1;
            slot = -1;
            for (int i = 0; i < N; i++) begin
                if (pick < 0 && m_busy[i] && m_t1[i] == 4'd0 && m_t2[i] == 4'd0) pick = i;
                if (slot < 0 && !m_busy[i]) slot = i;
            end
            assert (!(bus.rs_enable && slot < 0)) else $error("issue with no free entry");
            e_en = (pick >= 0);
            if (pick >= 0) begin
                e_op = m_op[pick]; e_v1 = m_v1[pick]; e_v2 = m_v2[pick];
                e_imm = m_imm[pick]; e_pc = m_pc[pick]; e_rob = m_rob[pick];
                m_busy[pick] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    m_v1[i] = pick_val(m_t1[i], m_v1[i]); m_t1[i] = pick_tag(m_t1[i]);
                    m_v2[i] = pick_val(m_t2[i], m_v2[i]); m_t2[i] = pick_tag(m_t2[i]);
                end
            end
            if (bus.rs_enable && slot >= 0) begin
                m_busy[slot] = 1'b1;
                m_op[slot]  = bus.issue_openum;
                m_v1[slot]  = bus.issue_rs1_val;  m_t1[slot] = bus.issue_rs1_rob_pos;
                m_v2[slot]  = bus.issue_rs2_val;  m_t2[slot] = bus.issue_rs2_rob_pos;
                m_imm[slot] = bus.issue_imm;      m_pc[slot] = bus.issue_pc;
                m_rob[slot] = bus.issue_rob_pos;
            end
        end
    end

    initial begin : compare
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("alu_enable", 32'(bus.alu_enable), 32'(e_en));
            chk("rs_full", 32'(bus.rs_full), 32'(exp_full()));
            chk("alu_openum", 32'(bus.alu_openum), 32'(e_op));
            chk("alu_rs1_val", bus.alu_rs1_val, e_v1);
            chk("alu_rs2_val", bus.alu_rs2_val, e_v2);
            chk("alu_imm", bus.alu_imm, e_imm);
            chk("alu_pc", bus.alu_pc, e_pc);
            chk("alu_rob_pos", 32'(bus.alu_rob_pos), 32'(e_rob));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.rdy = 1'b1; bus.rollback = 1'b0; bus.rs_enable = 1'b0;
        bus.alu_result_ready = 1'b0; bus.lsb_load_result_ready = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] v1, input logic [3:0] t1,
                         input logic [31:0] v2, input logic [3:0] t2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob);
        bus.rs_enable = 1'b1;
        bus.issue_openum = op;
        bus.issue_rs1_val = v1; bus.issue_rs1_rob_pos = t1;
        bus.issue_rs2_val = v2; bus.issue_rs2_rob_pos = t2;
        bus.issue_imm = imm; bus.issue_pc = pc; bus.issue_rob_pos = rob;
    endtask

    initial begin : stim
        rst = 1'b1;
        clr();
        issue(6'd0, '0, '0, '0, '0, '0, '0, '0);
        bus.rs_enable = 1'b0;
        bus.alu_result_rob_pos = '0; bus.alu_result_val = '0;
        bus.lsb_load_result_rob_pos = '0; bus.lsb_load_result_val = '0;
        step(); step();
        chk("reset alu_enable", 32'(bus.alu_enable), 32'd0);
        chk("reset rs_full", 32'(bus.rs_full), 32'd0);
        chk("reset alu_rs1_val", bus.alu_rs1_val, 32'd0);
        chk("reset alu_rob_pos", 32'(bus.alu_rob_pos), 32'd0);
        rst = 1'b0;

        // ADDI with ready operand: dispatch two cycles after issue
        issue(C_OP_ADDI, 32'd5, 4'd0, 32'd0, 4'd0, 32'd3, 32'h100, 4'd2);
        step(); clr();
        chk("addi not early", 32'(bus.alu_enable), 32'd0);
        step();
        chk("addi enable", 32'(bus.alu_enable), 32'd1);
        chk("addi rs1", bus.alu_rs1_val, 32'd5);
        chk("addi imm", bus.alu_imm, 32'd3);
        chk("addi rob", 32'(bus.alu_rob_pos), 32'd2);
        step();
        chk("addi one pulse", 32'(bus.alu_enable), 32'd0);

        // ADD waiting on tag 3, woken by ALU broadcast
        issue(C_OP_ADD, 32'd0, 4'd3, 32'd7, 4'd0, 32'd0, 32'h104, 4'd5);
        step(); clr();
        bus.alu_result_ready = 1'b1; bus.alu_result_rob_pos = 4'd3; bus.alu_result_val = 32'h10;
        step(); clr();
        chk("wake not early", 32'(bus.alu_enable), 32'd0);
        step();
        chk("wake enable", 32'(bus.alu_enable), 32'd1);
        chk("wake rs1", bus.alu_rs1_val, 32'h10);
        chk("wake rs2", bus.alu_rs2_val, 32'd7);
        step();

        // Simultaneous broadcasts on one tag: ALU value wins
        issue(C_OP_ADD, 32'd0, 4'd4, 32'd1, 4'd0, 32'd0, 32'h108, 4'd6);
        step(); clr();
        bus.alu_result_ready = 1'b1; bus.alu_result_rob_pos = 4'd4; bus.alu_result_val = 32'd1;
        bus.lsb_load_result_ready = 1'b1; bus.lsb_load_result_rob_pos = 4'd4;
        bus.lsb_load_result_val = 32'd2;
        step(); clr();
        step();
        chk("tie enable", 32'(bus.alu_enable), 32'd1);
        chk("tie rs1 alu wins", bus.alu_rs1_val, 32'd1);
        step();

        // Fill 15 entries waiting on tag 7, then release with one load broadcast
        for (int i = 0; i < 15; i++) begin
            issue(C_OP_ADD, 32'd0, 4'd7, 32'(i), 4'd0, 32'(i), 32'(i), 4'(i));
            step(); clr();
            if (i == 13) chk("full at 14", 32'(bus.rs_full), 32'd0);
            if (i == 14) chk("full at 15", 32'(bus.rs_full), 32'd1);
        end
        bus.lsb_load_result_ready = 1'b1; bus.lsb_load_result_rob_pos = 4'd7;
        bus.lsb_load_result_val = 32'd9;
        step(); clr();
        chk("drain pre enable", 32'(bus.alu_enable), 32'd0);
        for (int k = 0; k < 15; k++) begin
            step();
            chk("drain enable", 32'(bus.alu_enable), 32'd1);
            chk("drain rob order", 32'(bus.alu_rob_pos), 32'(k));
            chk("drain rs1", bus.alu_rs1_val, 32'd9);
            if (k == 0) chk("full drops at 14", 32'(bus.rs_full), 32'd0);
        end
        step();
        chk("drain done", 32'(bus.alu_enable), 32'd0);

        // rdy low holds a ready entry, then exactly one dispatch
        issue(C_OP_ADDI, 32'd11, 4'd0, 32'd0, 4'd0, 32'd4, 32'h200, 4'd5);
        step(); clr();
        bus.rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall no dispatch", 32'(bus.alu_enable), 32'd0);
        end
        bus.rdy = 1'b1;
        step();
        chk("stall release enable", 32'(bus.alu_enable), 32'd1);
        chk("stall release rs1", bus.alu_rs1_val, 32'd11);
        chk("stall release rob", 32'(bus.alu_rob_pos), 32'd5);
        step();
        chk("stall single pulse", 32'(bus.alu_enable), 32'd0);

        // Rollback coincident with issue flushes everything
        issue(C_OP_ADD, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 32'h300, 4'd1);
        step(); clr();
        issue(C_OP_ADD, 32'd0, 4'd9, 32'd0, 4'd0, 32'd0, 32'h304, 4'd2);
        step(); clr();
        issue(C_OP_ADDI, 32'd1, 4'd0, 32'd0, 4'd0, 32'd0, 32'h308, 4'd3);
        bus.rollback = 1'b1;
        step(); clr();
        chk("rollback enable", 32'(bus.alu_enable), 32'd0);
        chk("rollback full", 32'(bus.rs_full), 32'd0);
        bus.alu_result_ready = 1'b1; bus.alu_result_rob_pos = 4'd9; bus.alu_result_val = 32'd1;
        step(); clr();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post rollback idle", 32'(bus.alu_enable), 32'd0);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
